// File: rtl/inst_queue.sv
// Dual-issue instruction buffer between fetch and decode.
// Up to two {instruction, PC} pairs enter per cycle and the two oldest
// entries are always visible to decode. Outputs depend on registered
// state only, so fetch and decode stay timing-isolated from each other.
module inst_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en0,
    input  logic             wr_en1,
    input  logic [31:0]      wr_inst0,
    input  logic [31:0]      wr_pc0,
    input  logic [31:0]      wr_inst1,
    input  logic [31:0]      wr_pc1,
    input  logic [1:0]       issue_cnt,
    output logic             rd_valid0,
    output logic [31:0]      rd_inst0,
    output logic [31:0]      rd_pc0,
    output logic             rd_valid1,
    output logic [31:0]      rd_inst1,
    output logic [31:0]      rd_pc1,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_TWO = (PTR_W+1)'(2);
    // More than DEPTH-2 entries leaves fewer than two free slots.
    localparam logic [PTR_W:0]   FULL_TH = (PTR_W+1)'(DEPTH - 2);

    // Each entry packs {instruction, pc}.
    logic [63:0]      mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    logic [PTR_W-1:0] head1;
    logic [PTR_W-1:0] tail1;
    logic [1:0]       issue_clamped;
    logic [PTR_W:0]   issue_w;
    logic [PTR_W:0]   pop;
    logic [PTR_W:0]   push;
    logic             we0;
    logic             we1;

    assign head1 = head_q + PTR_ONE;
    assign tail1 = tail_q + PTR_ONE;

    assign full      = (cnt_q > FULL_TH);
    assign empty     = (cnt_q == '0);
    assign count     = cnt_q;
    assign rd_valid0 = (cnt_q != '0);
    assign rd_valid1 = (cnt_q >= CNT_TWO);

    assign rd_inst0 = rd_valid0 ? mem_q[head_q][63:32] : 32'd0;
    assign rd_pc0   = rd_valid0 ? mem_q[head_q][31:0]  : 32'd0;
    assign rd_inst1 = rd_valid1 ? mem_q[head1][63:32]  : 32'd0;
    assign rd_pc1   = rd_valid1 ? mem_q[head1][31:0]   : 32'd0;

    // Compute pop/push amounts and next pointers; flush overrides everything.
    always_comb begin
        issue_clamped = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;
        issue_w       = {{(PTR_W-1){1'b0}}, issue_clamped};
        // Decode may ask for more than is present; never pop past empty.
        pop           = (issue_w > cnt_q) ? cnt_q : issue_w;

        push = '0;
        if (!full && wr_en0) begin
            push = wr_en1 ? CNT_TWO : CNT_ONE;
        end

        we0 = !flush && (push != '0);
        we1 = !flush && (push == CNT_TWO);

        head_d = head_q + pop[PTR_W-1:0];
        tail_d = tail_q + push[PTR_W-1:0];
        cnt_d  = cnt_q - pop + push;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end
    end

    // Pointer and occupancy registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry storage; slot 1 lands one past slot 0, wrapping naturally.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem_q[tail_q] <= {wr_inst0, wr_pc0};
        end
        if (we1) begin
            mem_q[tail1] <= {wr_inst1, wr_pc1};
        end
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Dual-issue instruction buffer between instruction fetch and decode.
- Accepts up to two fetched instructions (with PCs) per cycle.
- Presents the two oldest entries to the decode/issue stage, whose immediate extension and operand logic consume them.
- Decouples fetch from issue stalls. Flushes on branch redirect or exception.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4.
- PTR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  discard all entries (redirect/exception).
- wr_en0  input  1  write slot 0 valid.
- wr_en1  input  1  write slot 1 valid; honoured only with wr_en0=1.
- wr_inst0  input  32  instruction, slot 0 (older).
- wr_pc0  input  32  PC, slot 0.
- wr_inst1  input  32  instruction, slot 1.
- wr_pc1  input  32  PC, slot 1.
- issue_cnt  input  2  entries consumed by decode this cycle (0..2; 3 treated as 2).
- rd_valid0  output  1  head entry present.
- rd_inst0  output  32  head instruction.
- rd_pc0  output  32  head PC.
- rd_valid1  output  1  second entry present.
- rd_inst1  output  32  second instruction.
- rd_pc1  output  32  second PC.
- full  output  1  fewer than 2 free entries; fetch must stall.
- empty  output  1  count==0.
- count  output  PTR_W+1  current occupancy.

Behaviour:
- State: head pointer, tail pointer (PTR_W bits, wrap modulo DEPTH), occupancy register cnt (PTR_W+1 bits), DEPTH x 64-bit storage.
- Reset (async, rst=1): head=0, tail=0, cnt=0. All outputs 0 except empty=1. Storage contents need not reset.
- Outputs are a function of registered state only. No combinational path from any input to any output.
- Read port:
  - rd_valid0 = (cnt>=1); rd_valid1 = (cnt>=2).
  - rd_inst0/rd_pc0 = entry[head] when rd_valid0, else 0.
  - rd_inst1/rd_pc1 = entry[head+1 mod DEPTH] when rd_valid1, else 0.
- Pop amount: pop = min(issue_cnt clamped to 2, cnt). Over-issue never underflows.
- Push:
  - push = 0 when full=1 (the value at the start of the cycle); both write slots are dropped.
  - Otherwise push = 2 if wr_en0&wr_en1, 1 if wr_en0 alone, 0 if wr_en0=0 (wr_en1 alone is ignored).
  - Slot 0 is written at tail, slot 1 at tail+1 mod DEPTH. tail advances by push.
- Simultaneous push and pop in one cycle are both applied. cnt_next = cnt - pop + push.
  - full guarantees 2 free slots before the cycle, so no overflow is possible.
- full = (cnt > DEPTH-2); empty = (cnt==0); count = cnt.
- Flush: on a rising edge with flush=1, head=0, tail=0, cnt=0. Flush has priority over push and pop in the same cycle; same-cycle writes are discarded. Outputs show empty on the next cycle.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no gap. A two-entry write or read may straddle the wrap point.
- Ordering: strict FIFO. Slot 0 is always older than slot 1. rd_*0 is always the oldest entry.
- Reset mid-operation: immediate return to reset state regardless of clk. Entries in flight are lost.

Test Plan:
- Reset then idle:
  - Hold rst=1 2 cycles, release → empty=1, full=0, count=0, rd_valid0=rd_valid1=0, rd_inst0=0.
- Dual push, single issue:
  - Cycle 1 write (0x24010005, pc 0xBFC00000) and (0x3C021234, pc 0xBFC00004) → count=2, rd_inst0=0x24010005, rd_pc1=0xBFC00004.
  - Next cycle issue_cnt=1 → count=1, rd_inst0=0x3C021234, rd_valid1=0.
- Fill to full:
  - 7 dual pushes with no issue (DEPTH=16) → count=14, full=0.
  - 8th dual push → count=16, full=1.
  - Further dual push is dropped, count stays 16.
  - issue_cnt=2 → count=14, full=0.
- Wrap-around:
  - Push/issue alternately until tail=15 and head=14.
  - Dual push writes entries 15 and 0.
  - Issue of 2 returns PCs in ascending order across the wrap, with no gaps.
- Over-issue and push concurrency:
  - count=1, issue_cnt=2, single push of pc 0x80000010 in the same cycle → count=1, rd_pc0=0x80000010.
- Flush priority and async reset:
  - count=5, flush=1 with a dual push in the same cycle → next cycle count=0, empty=1.
  - Assert rst between clock edges → outputs clear immediately.
